// File: rtl/ahb3lite_port_arbiter_if.sv
// Request/grant bundle between the AHB3-Lite switch fabric and one slave-port arbiter.
// The slave modport is the arbiter side; the master modport is the fabric side.
interface ahb3lite_port_arbiter_if #(
  parameter int MASTERS = 3,
  parameter int IDX_W   = $clog2(MASTERS)
);
  logic [MASTERS-1:0]      req;
  logic [MASTERS-1:0][2:0] mst_priority;
  logic [1:0]              HTRANS;
  logic [2:0]              HBURST;
  logic                    HMASTLOCK;
  logic                    HREADY;
  logic [MASTERS-1:0]      gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    switched;
  logic                    hold;

  modport slave (
    input  req, mst_priority, HTRANS, HBURST, HMASTLOCK, HREADY,
    output gnt, gnt_idx, switched, hold
  );

  modport master (
    output req, mst_priority, HTRANS, HBURST, HMASTLOCK, HREADY,
    input  gnt, gnt_idx, switched, hold
  );
endinterface

// File: rtl/ahb3lite_port_arbiter.sv
// Per-slave-port master arbiter: priority select with round-robin among equal priorities,
// holding ownership across fixed bursts, open INCR bursts, BUSY beats and locked sequences.
module ahb3lite_port_arbiter #(
  parameter int MASTERS = 3,
  parameter int IDX_W   = $clog2(MASTERS)
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb3lite_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'd0,
    BU_INCR   = 3'd1,
    BU_WRAP4  = 3'd2,
    BU_INCR4  = 3'd3,
    BU_WRAP8  = 3'd4,
    BU_INCR8  = 3'd5,
    BU_WRAP16 = 3'd6,
    BU_INCR16 = 3'd7
  } hburst_e;

  htrans_e            trans;
  hburst_e            burst;
  logic [3:0]         cnt_q;
  logic [3:0]         cnt_next;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic [IDX_W-1:0]   gnt_idx_next;
  logic [IDX_W-1:0]   win_idx;
  logic [MASTERS-1:0] gnt_q;
  logic [MASTERS-1:0] gnt_next;
  logic [MASTERS-1:0] cand;
  logic [2:0]         max_pri;
  logic               switched_q;
  logic               hold_w;
  logic               found;
  int                 scan_idx;

  assign trans = htrans_e'(bus.HTRANS);
  assign burst = hburst_e'(bus.HBURST);

  // Remaining beats of the owner's fixed-length burst after this edge.
  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_next = cnt_q;
    unique case (trans)
      TR_IDLE: cnt_next = 4'd0;
      TR_BUSY: cnt_next = cnt_q;
      TR_SEQ:  cnt_next = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      TR_NONSEQ: begin
        unique case (burst)
          BU_WRAP4,  BU_INCR4:  cnt_next = 4'd3;
          BU_WRAP8,  BU_INCR8:  cnt_next = 4'd7;
          BU_WRAP16, BU_INCR16: cnt_next = 4'd15;
          default:              cnt_next = 4'd0;
        endcase
      end
      default: cnt_next = cnt_q;
    endcase
  end

  // An open INCR burst stays owned only while its master keeps requesting.
  assign hold_w = bus.HMASTLOCK
               || (trans == TR_BUSY)
               || (cnt_next != 4'd0)
               || ((burst == BU_INCR) && (trans == TR_NONSEQ || trans == TR_SEQ)
                   && bus.req[gnt_idx_q]);

  // Highest priority among requesters, then first candidate after the owner with wrap.
  always_comb begin
    max_pri  = 3'd0;
    cand     = '0;
    win_idx  = gnt_idx_q;
    found    = 1'b0;
    scan_idx = 0;
    for (int m = 0; m < MASTERS; m++) begin
      if (bus.req[m] && (bus.mst_priority[m] > max_pri)) max_pri = bus.mst_priority[m];
    end
    for (int m = 0; m < MASTERS; m++) begin
      cand[m] = bus.req[m] && (bus.mst_priority[m] == max_pri);
    end
    for (int i = 1; i <= MASTERS; i++) begin
      scan_idx = (int'(gnt_idx_q) + i) % MASTERS;
      if (!found && cand[scan_idx]) begin
        win_idx = IDX_W'(scan_idx);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_idx_next = gnt_idx_q;
    if (bus.HREADY && !hold_w && found) gnt_idx_next = win_idx;
    gnt_next = {{(MASTERS-1){1'b0}}, 1'b1} << gnt_idx_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q      <= 4'd0;
      gnt_idx_q  <= '0;
      gnt_q      <= {{(MASTERS-1){1'b0}}, 1'b1};
      switched_q <= 1'b0;
    end else begin
      if (bus.HREADY) cnt_q <= cnt_next;
      gnt_idx_q  <= gnt_idx_next;
      gnt_q      <= gnt_next;
      switched_q <= (gnt_idx_next != gnt_idx_q);
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_idx  = gnt_idx_q;
  assign bus.switched = switched_q;
  assign bus.hold     = hold_w;

endmodule

// File: tb/tb_ahb3lite_port_arbiter.sv
// Directed bench for ahb3lite_port_arbiter: stimulus pushes hand-computed expectations,
// a monitor checks hold before each edge and gnt/gnt_idx/switched after it.
module tb_ahb3lite_port_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR   = 3'd1;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] WRAP8  = 3'd4;
  localparam logic [2:0] INCR8  = 3'd5;

  typedef struct {
    int         id;
    logic [2:0] gnt;
    logic [1:0] idx;
    logic       sw;
    logic       hold;
  } exp_t;

  logic HCLK;
  logic HRESETn;
  int   n_checks;
  int   n_fail;
  int   beat_id;
  exp_t sb[$];

  ahb3lite_port_arbiter_if #(.MASTERS(3)) bus ();

  ahb3lite_port_arbiter #(.MASTERS(3)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pri(input logic [2:0] p0, input logic [2:0] p1, input logic [2:0] p2);
    @(posedge HCLK);
    #1;
    bus.mst_priority[0] = p0;
    bus.mst_priority[1] = p1;
    bus.mst_priority[2] = p2;
  endtask

  // One address-phase cycle: drive at the falling edge, expect the result of the next rising edge.
  task automatic beat(input logic [2:0] r, input logic [1:0] tr, input logic [2:0] bu,
                      input logic lk, input logic rdy,
                      input int e_idx, input logic e_sw, input logic e_hold);
    exp_t e;
    @(negedge HCLK);
    bus.req       = r;
    bus.HTRANS    = tr;
    bus.HBURST    = bu;
    bus.HMASTLOCK = lk;
    bus.HREADY    = rdy;
    beat_id++;
    e.id   = beat_id;
    e.gnt  = 3'b001 << e_idx;
    e.idx  = 2'(e_idx);
    e.sw   = e_sw;
    e.hold = e_hold;
    sb.push_back(e);
  endtask

  // Monitor: hold is combinational from the driven inputs; registered outputs follow the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      #1;
      if (sb.size() > 0) begin
        e = sb[0];
        check($sformatf("hold[%0d]", e.id), 32'(bus.hold), 32'(e.hold));
        @(posedge HCLK);
        #1;
        e = sb.pop_front();
        check($sformatf("gnt[%0d]", e.id),      32'(bus.gnt),      32'(e.gnt));
        check($sformatf("gnt_idx[%0d]", e.id),  32'(bus.gnt_idx),  32'(e.idx));
        check($sformatf("switched[%0d]", e.id), 32'(bus.switched), 32'(e.sw));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    beat_id  = 0;
    HRESETn  = 1'b0;
    bus.req = '0;
    bus.HTRANS = IDLE;
    bus.HBURST = SINGLE;
    bus.HMASTLOCK = 1'b0;
    bus.HREADY = 1'b1;
    bus.mst_priority = '0;
    #12;
    check("rst_gnt",      32'(bus.gnt),      32'h1);
    check("rst_gnt_idx",  32'(bus.gnt_idx),  32'h0);
    check("rst_switched", 32'(bus.switched), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Priority select: master 1 has the highest priority, then parks with no requests.
    set_pri(3'd1, 3'd5, 3'd3);
    beat(3'b111, IDLE, SINGLE, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    beat(3'b000, IDLE, SINGLE, 1'b0, 1'b1, 1, 1'b0, 1'b0);

    // Round-robin among equal priorities, one switch per accepted SINGLE.
    set_pri(3'd2, 3'd2, 3'd2);
    beat(3'b001, IDLE,   SINGLE, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    beat(3'b111, NONSEQ, SINGLE, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    beat(3'b111, NONSEQ, SINGLE, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    beat(3'b111, NONSEQ, SINGLE, 1'b0, 1'b1, 2, 1'b1, 1'b0);
    beat(3'b111, NONSEQ, SINGLE, 1'b0, 1'b1, 0, 1'b1, 1'b0);

    // INCR4 from master 0 holds against higher-priority master 2 until the 4th beat.
    set_pri(3'd1, 3'd1, 3'd6);
    beat(3'b101, NONSEQ, INCR4, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    beat(3'b101, SEQ,    INCR4, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    beat(3'b101, SEQ,    INCR4, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    beat(3'b101, SEQ,    INCR4, 1'b0, 1'b1, 2, 1'b1, 1'b0);

    // Same burst with two wait states per beat; hold drops during the 4th beat's waits.
    beat(3'b001, IDLE, SINGLE, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    for (int b = 1; b <= 4; b++) begin
      for (int w = 0; w < 3; w++) begin
        beat(3'b101, (b == 1) ? NONSEQ : SEQ, INCR4, 1'b0, (w == 2),
             (b == 4 && w == 2) ? 2 : 0, (b == 4 && w == 2), (b < 4));
      end
    end

    // Locked SINGLEs (with a wait state) keep master 1; unlocking releases it.
    set_pri(3'd4, 3'd4, 3'd4);
    beat(3'b010, IDLE,   SINGLE, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    beat(3'b111, NONSEQ, SINGLE, 1'b1, 1'b1, 1, 1'b0, 1'b1);
    beat(3'b111, NONSEQ, SINGLE, 1'b1, 1'b0, 1, 1'b0, 1'b1);
    beat(3'b111, NONSEQ, SINGLE, 1'b1, 1'b1, 1, 1'b0, 1'b1);
    beat(3'b111, NONSEQ, SINGLE, 1'b1, 1'b1, 1, 1'b0, 1'b1);
    beat(3'b111, NONSEQ, SINGLE, 1'b0, 1'b1, 2, 1'b1, 1'b0);

    // WRAP8 aborted by IDLE after two beats hands over at that edge.
    beat(3'b010, IDLE, SINGLE, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    set_pri(3'd4, 3'd4, 3'd5);
    beat(3'b111, NONSEQ, WRAP8, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    beat(3'b111, SEQ,    WRAP8, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    beat(3'b111, IDLE,   WRAP8, 1'b0, 1'b1, 2, 1'b1, 1'b0);

    // Open INCR with a BUSY beat holds while master 2 requests, released when it drops req.
    set_pri(3'd7, 3'd4, 3'd5);
    beat(3'b111, NONSEQ, INCR, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    beat(3'b101, BUSY,   INCR, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    beat(3'b101, SEQ,    INCR, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    beat(3'b001, SEQ,    INCR, 1'b0, 1'b1, 0, 1'b1, 1'b0);

    // A new NONSEQ mid-burst reloads the count, so master 0 keeps the port.
    set_pri(3'd1, 3'd7, 3'd1);
    beat(3'b011, NONSEQ, INCR4, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    beat(3'b011, SEQ,    INCR4, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    beat(3'b011, NONSEQ, INCR4, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    beat(3'b011, SEQ,    INCR4, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    beat(3'b011, SEQ,    INCR4, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    beat(3'b011, SEQ,    INCR4, 1'b0, 1'b1, 1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of an INCR8 owned by master 1.
    beat(3'b111, NONSEQ, INCR8, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    beat(3'b111, SEQ,    INCR8, 1'b0, 1'b1, 1, 1'b0, 1'b1);
    @(posedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    check("midrst_gnt",      32'(bus.gnt),      32'h1);
    check("midrst_gnt_idx",  32'(bus.gnt_idx),  32'h0);
    check("midrst_switched", 32'(bus.switched), 32'h0);
    check("midrst_hold",     32'(bus.hold),     32'h0);
    @(negedge HCLK);
    bus.req    = '0;
    bus.HTRANS = IDLE;
    bus.HBURST = SINGLE;
    HRESETn    = 1'b1;

    // Arbitration restarts from master 0: the first tie goes to master 1.
    set_pri(3'd3, 3'd3, 3'd3);
    beat(3'b111, NONSEQ, SINGLE, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    beat(3'b000, IDLE,   SINGLE, 1'b0, 1'b1, 1, 1'b0, 1'b0);

    repeat (4) @(posedge HCLK);
    #2;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
